mem_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch stage and the data-access (load/store) stage. It holds one outstanding transaction at a time and drives the memory request/accept/response handshake. It generates the fetch-stage stall and the data-stage stall. When a taken branch occurs during a fetch, it kills that in-flight fetch so the stale instruction is never delivered.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arb_prio.sv | 38 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, transaction
// owner and the default data-burst limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int MAX_D_BURST_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data, with a saturating count of data
// grants taken while a fetch waits so that fetch cannot starve.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_if,
    output logic grant_d
);

    localparam int CNT_W = $clog2(MAX_D_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

    logic [CNT_W-1:0] burst_cnt;
    logic             fetch_forced;

    assign fetch_forced = if_req & (burst_cnt == CNT_MAX);
    assign grant_d      = grant_en & d_req & ~fetch_forced;
    assign grant_if     = grant_en & if_req & ~grant_d;

    // An idle cycle with no fetch waiting forgets any earlier data burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (grant_if || (grant_en && !if_req)) begin
            burst_cnt <= '0;
        end else if (grant_d && if_req && (burst_cnt != CNT_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one unified memory between instruction
// fetch and load/store, with branch-flush kill of an in-flight fetch.
//   state   | meaning
//   IDLE    | no transaction; grant a pending request and latch its payload
//   REQ     | mem_req high, waiting for mem_ready
//   WAIT    | accepted, waiting for mem_rvalid to deliver (or drop if killed)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t        state, state_nxt;
    owner_t            owner, owner_nxt;
    logic              kill, kill_nxt;
    logic              grant_en, grant_if, grant_d;
    logic              resp, flush_if;
    logic              deliver_if, deliver_d;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    mem_arb_prio #(
        .MAX_D_BURST(MAX_D_BURST)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    assign grant_en = (state == ST_IDLE);
    assign resp     = (state == ST_WAIT) & mem_rvalid;
    assign flush_if = if_flush & (owner == OWN_IF);

    // A flush arriving with the response suppresses it in the same cycle.
    assign deliver_if = resp & (owner == OWN_IF) & ~kill & ~if_flush;
    assign deliver_d  = resp & (owner == OWN_D);

    assign if_valid = deliver_if;
    assign d_valid  = deliver_d;
    assign if_rdata = deliver_if ? mem_rdata : if_rdata_q;
    assign d_rdata  = deliver_d  ? mem_rdata : d_rdata_q;
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;
    assign mem_req  = (state == ST_REQ);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        kill_nxt  = kill;
        case (state)
            ST_IDLE: begin
                kill_nxt = 1'b0;
                if (grant_d) begin
                    state_nxt = ST_REQ;
                    owner_nxt = OWN_D;
                end else if (grant_if) begin
                    state_nxt = ST_REQ;
                    owner_nxt = OWN_IF;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_nxt = ST_WAIT;
                    kill_nxt  = flush_if;
                end else if (flush_if) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = ST_IDLE;
                    kill_nxt  = 1'b0;
                end else if (flush_if) begin
                    kill_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                kill_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= OWN_IF;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            kill  <= kill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_if) begin
            mem_we    <= 1'b0;
            mem_be    <= '1;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (deliver_if) if_rdata_q <= mem_rdata;
            if (deliver_d)  d_rdata_q  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed flush/reset/starvation cases and
// randomized fetch/data mixes against a queue-based ordering and memory model.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req, if_flush, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [3:0]    d_be;
    logic [DW-1:0] d_wdata, if_rdata, d_rdata;
    logic          if_valid, if_stall, d_valid, d_stall;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct { bit is_if; bit chk; logic [31:0] data; } exp_t;
    typedef struct { bit we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } dop_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    dop_t        d_ops[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] last_if = '0;

    int          ready_mode = 1;
    bit          ready_val  = 1'b1;
    int          fix_delay  = 1;
    int          accepts    = 0;
    bit          resp_pending = 1'b0;
    int          resp_cnt   = 0;
    logic [31:0] resp_data  = '0;

    function automatic logic [31:0] init_val(logic [31:0] a);
        if (a == 32'h0)   return 32'h00500093;
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
        logic [31:0] r = old_v;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Expected delivery order: data first, but after MAX_D_BURST data grants
    // with the fetch waiting, the fetch goes next.
    task automatic plan(input bit has_if, input logic [31:0] if_a);
        int  burst = 0;
        int  di    = 0;
        bit  fi    = has_if;
        while (di < d_ops.size() || fi) begin
            if (di < d_ops.size() && !(fi && burst == MAXB)) begin
                if (d_ops[di].we) begin
                    ref_mem[d_ops[di].addr] = merge(ref_read(d_ops[di].addr), d_ops[di].wdata, d_ops[di].be);
                    exp_q.push_back('{is_if: 1'b0, chk: 1'b0, data: 32'h0});
                end else begin
                    exp_q.push_back('{is_if: 1'b0, chk: 1'b1, data: ref_read(d_ops[di].addr)});
                end
                if (fi && burst < MAXB) burst++;
                di++;
            end else begin
                exp_q.push_back('{is_if: 1'b1, chk: 1'b1, data: ref_read(if_a)});
                fi    = 1'b0;
                burst = 0;
            end
        end
    endtask

    task automatic wait_if();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("if_valid_wait");
    endtask

    task automatic wait_d();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("d_valid_wait");
    endtask

    task automatic wait_sig(input int which, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((which == 0 && mem_req) || (which == 1 && mem_req && mem_ready) ||
                (which == 2 && mem_rvalid)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic run_if(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
        wait_if();
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic run_d();
        for (int i = 0; i < d_ops.size(); i++) begin
            d_req   = 1'b1;
            d_we    = d_ops[i].we;
            d_be    = d_ops[i].be;
            d_addr  = d_ops[i].addr;
            d_wdata = d_ops[i].wdata;
            wait_d();
            @(posedge clk); #1;
        end
        d_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory responder: one-cycle-minimum response latency, own storage.
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk); #2;
            mem_rvalid = 1'b0;
            if (resp_pending) begin
                if (resp_cnt == 0) begin
                    mem_rvalid   = 1'b1;
                    mem_rdata    = resp_data;
                    resp_pending = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
            mem_ready = (ready_mode != 0) ? ready_val : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (mem_req && mem_ready) begin
                accepts++;
                check("single_outstanding", {31'h0, resp_pending}, 32'h0);
                if (mem_we) begin
                    mem_arr[mem_addr] = merge(mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr),
                                              mem_wdata, mem_be);
                    resp_data = $urandom;
                end else begin
                    resp_data = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr);
                end
                resp_pending = 1'b1;
                resp_cnt     = ((fix_delay != 0) ? fix_delay : int'($urandom_range(1, 3))) - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("if_stall_eq", {31'h0, if_stall}, {31'h0, if_req & ~if_valid});
        check("d_stall_eq", {31'h0, d_stall}, {31'h0, d_req & ~d_valid});
        if (if_valid && d_valid) check("both_valid", 32'h1, 32'h0);
        if (if_valid || d_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=if%0b/d%0b expected=none", if_valid, d_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("delivery_owner", {31'h0, if_valid}, {31'h0, mon_e.is_if});
                if (mon_e.chk && mon_e.is_if == if_valid)
                    check(mon_e.is_if ? "if_rdata" : "d_rdata", mon_e.is_if ? if_rdata : d_rdata, mon_e.data);
                if (mon_e.is_if) last_if = mon_e.data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0]    vpat, spat;
        int          acc;
        int          nd;
        bit          has_if;
        logic [31:0] if_a;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        idle(2);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        idle(2);

        // Fetch only, minimum latency.
        ready_mode = 1; ready_val = 1'b1; fix_delay = 1;
        exp_q.push_back('{is_if: 1'b1, chk: 1'b1, data: 32'h00500093});
        if_req = 1'b1; if_addr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vpat[c] = if_valid;
            spat[c] = if_stall;
        end
        check("t1_valid_cycle", {29'h0, vpat}, 32'h4);
        check("t1_stall_cycles", {29'h0, spat}, 32'h3);
        @(posedge clk); #1; if_req = 1'b0;
        idle(2);

        // Simultaneous load and fetch: data first.
        d_ops = {};
        d_ops.push_back('{we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0});
        plan(1'b1, 32'h4);
        fork run_d(); run_if(32'h4); join
        idle(2);

        // Starvation: six stores against a held fetch.
        d_ops = {};
        for (int i = 0; i < 6; i++)
            d_ops.push_back('{we: 1'b1, be: 4'(int'($urandom_range(1, 15))), addr: 32'h100 + 32'(4 * i), wdata: $urandom});
        plan(1'b1, 32'hC);
        fork run_d(); run_if(32'hC); join
        idle(2);
        d_ops = {};
        for (int i = 0; i < 6; i++) d_ops.push_back('{we: 1'b0, be: 4'hF, addr: 32'h100 + 32'(4 * i), wdata: 32'h0});
        plan(1'b0, 32'h0);
        run_d();
        idle(2);

        // Flush while waiting for the response.
        fix_delay = 4;
        if_req = 1'b1; if_addr = 32'h8;
        wait_sig(1, "t4_accept");
        @(posedge clk); #1; if_flush = 1'b1; if_addr = 32'h40; fix_delay = 1;
        exp_q.push_back('{is_if: 1'b1, chk: 1'b1, data: ref_read(32'h40)});
        @(posedge clk); #1; if_flush = 1'b0;
        wait_sig(2, "t4_killed_rvalid");
        check("t4_killed_no_valid", {31'h0, if_valid}, 32'h0);
        check("t4_if_rdata_held", if_rdata, last_if);
        wait_if();
        @(posedge clk); #1; if_req = 1'b0;
        idle(2);

        // Flush in the same cycle as the response.
        fix_delay = 2;
        if_req = 1'b1; if_addr = 32'h14;
        wait_sig(1, "t4b_accept");
        @(posedge clk); #1;
        @(posedge clk); #1; if_flush = 1'b1; if_addr = 32'h50; fix_delay = 1;
        exp_q.push_back('{is_if: 1'b1, chk: 1'b1, data: ref_read(32'h50)});
        @(negedge clk);
        check("t4b_rvalid_present", {31'h0, mem_rvalid}, 32'h1);
        check("t4b_suppressed", {31'h0, if_valid}, 32'h0);
        @(posedge clk); #1; if_flush = 1'b0;
        wait_if();
        @(posedge clk); #1; if_req = 1'b0;
        idle(2);

        // Flush in REQ with memory not ready: abort.
        ready_val = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        wait_sig(0, "t5a_req");
        acc = accepts;
        @(posedge clk); #1; if_flush = 1'b1; if_addr = 32'h44;
        @(posedge clk); #1; if_flush = 1'b0; ready_val = 1'b1;
        exp_q.push_back('{is_if: 1'b1, chk: 1'b1, data: ref_read(32'h44)});
        @(negedge clk);
        check("t5a_mem_req_drop", {31'h0, mem_req}, 32'h0);
        check("t5a_no_accept", accepts, acc);
        wait_if();
        @(posedge clk); #1; if_req = 1'b0;
        check("t5a_one_accept", accepts, acc + 1);
        idle(2);

        // Flush in REQ accepted the same cycle: killed response.
        ready_val = 1'b0;
        if_req = 1'b1; if_addr = 32'h18;
        wait_sig(0, "t5b_req");
        acc = accepts;
        @(posedge clk); #1; if_flush = 1'b1; if_addr = 32'h48; ready_val = 1'b1; fix_delay = 2;
        exp_q.push_back('{is_if: 1'b1, chk: 1'b1, data: ref_read(32'h48)});
        @(posedge clk); #1; if_flush = 1'b0;
        wait_sig(2, "t5b_killed_rvalid");
        check("t5b_killed_no_valid", {31'h0, if_valid}, 32'h0);
        check("t5b_if_rdata_held", if_rdata, last_if);
        wait_if();
        @(posedge clk); #1; if_req = 1'b0;
        check("t5b_two_accepts", accepts, acc + 2);
        idle(2);

        // Reset during WAIT, late response afterwards.
        fix_delay = 5;
        if_req = 1'b1; if_addr = 32'h20;
        wait_sig(1, "t6_accept");
        @(posedge clk); #3; rst_n = 1'b0;
        #1;
        check("t6_mem_req", {31'h0, mem_req}, 32'h0);
        check("t6_mem_we_be", {27'h0, mem_we, mem_be}, 32'h0);
        check("t6_mem_addr", mem_addr, 32'h0);
        check("t6_mem_wdata", mem_wdata, 32'h0);
        check("t6_if_rdata", if_rdata, 32'h0);
        check("t6_valids", {30'h0, if_valid, d_valid}, 32'h0);
        check("t6_if_stall", {31'h0, if_stall}, 32'h1);
        if_req = 1'b0; last_if = '0;
        @(negedge clk); rst_n = 1'b1;
        idle(8);
        check("t6_if_rdata_after", if_rdata, 32'h0);
        fix_delay = 1;

        // Randomized mixes.
        ready_mode = 0; fix_delay = 0;
        for (int it = 0; it < 40; it++) begin
            nd     = int'($urandom_range(0, 6));
            has_if = (nd == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if_a   = 32'(4 * $urandom_range(0, 31));
            d_ops  = {};
            for (int i = 0; i < nd; i++) begin
                bit we = 1'($urandom_range(0, 1));
                d_ops.push_back('{we: we, be: we ? 4'(int'($urandom_range(1, 15))) : 4'hF,
                                  addr: 32'h100 + 32'(4 * $urandom_range(0, 15)), wdata: $urandom});
            end
            plan(has_if, if_a);
            fork
                run_d();
                begin if (has_if) run_if(if_a); end
            join
            idle(int'($urandom_range(1, 3)));
        end
        idle(6);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
